// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle shared by the in-order pipeline, the long-latency
// unit and the arbiter that owns the write port.
interface wb_port_arbiter_if #(
    parameter int XLEN = 64
);
    logic            pipe_valid_i;
    logic            pipe_rd_wen_i;
    logic [4:0]      pipe_rd_addr_i;
    logic [XLEN-1:0] pipe_rd_data_i;
    logic            pipe_mem_read_i;
    logic [XLEN-1:0] pipe_mem_rdata_i;
    logic            pipe_stall_o;
    logic            lu_valid_i;
    logic [4:0]      lu_rd_addr_i;
    logic [XLEN-1:0] lu_rd_data_i;
    logic            lu_ready_o;
    logic            wb_rd_wen_o;
    logic [4:0]      wb_rd_addr_o;
    logic [XLEN-1:0] wb_rd_wdata_o;

    modport slave (
        input  pipe_valid_i, pipe_rd_wen_i, pipe_rd_addr_i, pipe_rd_data_i,
               pipe_mem_read_i, pipe_mem_rdata_i,
               lu_valid_i, lu_rd_addr_i, lu_rd_data_i,
        output pipe_stall_o, lu_ready_o, wb_rd_wen_o, wb_rd_addr_o, wb_rd_wdata_o
    );

    modport master (
        output pipe_valid_i, pipe_rd_wen_i, pipe_rd_addr_i, pipe_rd_data_i,
               pipe_mem_read_i, pipe_mem_rdata_i,
               lu_valid_i, lu_rd_addr_i, lu_rd_data_i,
        input  pipe_stall_o, lu_ready_o, wb_rd_wen_o, wb_rd_addr_o, wb_rd_wdata_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline has priority, a starvation guard forces one
// long-unit grant after STARVE_LIMIT consecutive denials. Write outputs are registered.
//
// state   | meaning
// S_ARB   | pipeline wins when it writes rd; long unit takes idle slots and counts denials
// S_FORCE | one-cycle forced long-unit grant; a writing pipeline instruction is stalled
module wb_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic {S_ARB, S_FORCE} state_e;

    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wen_q, wen_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            pipe_req;
    logic [XLEN-1:0] pipe_data;
    logic            lu_ready;
    logic            pipe_stall;
    logic            lu_xfer;
    logic            pipe_win;

    assign pipe_req  = bus.pipe_valid_i & bus.pipe_rd_wen_i;
    assign pipe_data = bus.pipe_mem_read_i ? bus.pipe_mem_rdata_i : bus.pipe_rd_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ARB;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_ARB: begin
                if (bus.lu_valid_i && !lu_ready) begin
                    if (cnt_q == LIMIT_M1) begin
                        state_d = S_FORCE;
                    end else if (cnt_q != 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            S_FORCE: state_d = S_ARB;
            default: state_d = S_ARB;
        endcase
    end

    always_comb begin
        lu_ready   = 1'b0;
        pipe_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                S_ARB:   lu_ready = bus.lu_valid_i & ~pipe_req;
                S_FORCE: begin
                    lu_ready   = bus.lu_valid_i;
                    // A vanished long-unit request must not freeze the pipeline.
                    pipe_stall = pipe_req & bus.lu_valid_i;
                end
                default: lu_ready = 1'b0;
            endcase
        end
        lu_xfer  = bus.lu_valid_i & lu_ready;
        pipe_win = pipe_req & ~pipe_stall & ~lu_xfer;

        wen_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (lu_xfer) begin
            wen_d  = (bus.lu_rd_addr_i != 5'd0);
            addr_d = bus.lu_rd_addr_i;
            data_d = bus.lu_rd_data_i;
        end else if (pipe_win) begin
            wen_d  = (bus.pipe_rd_addr_i != 5'd0);
            addr_d = bus.pipe_rd_addr_i;
            data_d = pipe_data;
        end
    end

    assign bus.lu_ready_o    = lu_ready;
    assign bus.pipe_stall_o  = pipe_stall;
    assign bus.wb_rd_wen_o   = wen_q;
    assign bus.wb_rd_addr_o  = addr_q;
    assign bus.wb_rd_wdata_o = data_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors push expected handshake and
// write results; a negedge monitor pops and compares them.
module tb_wb_port_arbiter;
    localparam int XLEN = 64;

    typedef struct {
        int   cyc;
        logic stall;
        logic ready;
    } comb_exp_t;

    typedef struct {
        int              cyc;
        logic            wen;
        logic            chk;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wr_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    comb_exp_t cq[$];
    wr_exp_t   wq[$];

    wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        comb_exp_t c;
        wr_exp_t   w;
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            c = cq.pop_front();
            total++;
            if (bus.pipe_stall_o !== c.stall || bus.lu_ready_o !== c.ready) begin
                bad++;
                $display("FAIL handshake cyc=%0d stall got=%b exp=%b ready got=%b exp=%b",
                         cyc, bus.pipe_stall_o, c.stall, bus.lu_ready_o, c.ready);
            end
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            w = wq.pop_front();
            total++;
            if (bus.wb_rd_wen_o !== w.wen ||
                (w.chk && (bus.wb_rd_addr_o !== w.addr || bus.wb_rd_wdata_o !== w.data))) begin
                bad++;
                $display("FAIL write cyc=%0d wen got=%b exp=%b addr got=%0d exp=%0d data got=%h exp=%h",
                         cyc, bus.wb_rd_wen_o, w.wen, bus.wb_rd_addr_o, w.addr,
                         bus.wb_rd_wdata_o, w.data);
            end
        end
    end

    task automatic drive(input logic pv, input logic pw, input logic [4:0] pa,
                         input logic [XLEN-1:0] pd, input logic mr, input logic [XLEN-1:0] md,
                         input logic lv, input logic [4:0] la, input logic [XLEN-1:0] ld,
                         input logic es, input logic er, input logic ew, input logic ec,
                         input logic [4:0] ea, input logic [XLEN-1:0] ed);
        comb_exp_t c;
        wr_exp_t   w;
        bus.pipe_valid_i     = pv;
        bus.pipe_rd_wen_i    = pw;
        bus.pipe_rd_addr_i   = pa;
        bus.pipe_rd_data_i   = pd;
        bus.pipe_mem_read_i  = mr;
        bus.pipe_mem_rdata_i = md;
        bus.lu_valid_i       = lv;
        bus.lu_rd_addr_i     = la;
        bus.lu_rd_data_i     = ld;
        c.cyc = cyc;     c.stall = es; c.ready = er;
        w.cyc = cyc + 1; w.wen = ew;   w.chk = ec; w.addr = ea; w.data = ed;
        cq.push_back(c);
        wq.push_back(w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.pipe_valid_i = 0; bus.pipe_rd_wen_i = 0; bus.pipe_rd_addr_i = 0;
        bus.pipe_rd_data_i = 0; bus.pipe_mem_read_i = 0; bus.pipe_mem_rdata_i = 0;
        bus.lu_valid_i = 0; bus.lu_rd_addr_i = 0; bus.lu_rd_data_i = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset: handshakes suppressed, write register cleared
        drive(1, 1, 5'd4, 64'h44, 0, 0, 1, 5'd8, 64'h88, 0, 0, 0, 1, 5'd0, 64'h0);
        rst = 1'b0;

        // pipeline only, ALU then load data
        drive(1, 1, 5'd5, 64'h11, 0, 64'h0,  0, 0, 0, 0, 0, 1, 1, 5'd5, 64'h11);
        drive(1, 1, 5'd5, 64'h33, 1, 64'h22, 0, 0, 0, 0, 0, 1, 1, 5'd5, 64'h22);

        // idle pipe: long unit accepted at once; then no winner holds addr/data
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 64'hABCD, 0, 1, 1, 1, 5'd7, 64'hABCD);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 5'd7, 64'hABCD);

        // starvation: four pipeline writes, then forced long-unit grant
        for (int i = 1; i <= 4; i++)
            drive(1, 1, 5'(i), 64'(256 + i), 0, 0, 1, 5'd9, 64'h99,
                  0, 0, 1, 1, 5'(i), 64'(256 + i));
        drive(1, 1, 5'd5, 64'h105, 0, 0, 1, 5'd9, 64'h99, 1, 1, 1, 1, 5'd9, 64'h99);

        // stalled instruction retires unchanged; new long-unit result counts from zero
        for (int i = 5; i <= 8; i++)
            drive(1, 1, 5'(i), 64'(256 + i), 0, 0, 1, 5'd10, 64'hAA,
                  0, 0, 1, 1, 5'(i), 64'(256 + i));
        drive(1, 1, 5'd9, 64'h109, 0, 0, 1, 5'd10, 64'hAA, 1, 1, 1, 1, 5'd10, 64'hAA);
        drive(1, 1, 5'd9, 64'h109, 0, 0, 0, 0, 0,          0, 0, 1, 1, 5'd9, 64'h109);

        // non-writing pipeline instruction leaves the port to the long unit
        drive(1, 0, 5'd3, 64'h33, 0, 0, 1, 5'd12, 64'hC, 0, 1, 1, 1, 5'd12, 64'hC);

        // x0 destinations: granted but never written
        drive(1, 1, 5'd0, 64'hFF, 0, 0, 0, 0, 0,         0, 0, 0, 0, 5'd0, 64'h0);
        drive(0, 0, 0, 0, 0, 0,   1, 5'd0, 64'h5,        0, 1, 0, 0, 5'd0, 64'h0);

        // reset mid-wait discards two denials
        drive(1, 1, 5'd20, 64'h120, 0, 0, 1, 5'd13, 64'hD, 0, 0, 1, 1, 5'd20, 64'h120);
        drive(1, 1, 5'd21, 64'h121, 0, 0, 1, 5'd13, 64'hD, 0, 0, 1, 1, 5'd21, 64'h121);
        rst = 1'b1;
        drive(1, 1, 5'd22, 64'h122, 0, 0, 1, 5'd13, 64'hD, 0, 0, 0, 1, 5'd0, 64'h0);
        rst = 1'b0;
        for (int i = 22; i <= 25; i++)
            drive(1, 1, 5'(i), 64'(256 + i), 0, 0, 1, 5'd13, 64'hD,
                  0, 0, 1, 1, 5'(i), 64'(256 + i));
        // forced cycle with a non-writing pipe instruction: no stall
        drive(1, 0, 5'd26, 64'h126, 0, 0, 1, 5'd13, 64'hD, 0, 1, 1, 1, 5'd13, 64'hD);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 1, 5'd13, 64'hD);

        @(negedge clk);
        #1;
        total++;
        if (cq.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL drain leftover handshake=%0d write=%0d expected 0",
                     cq.size(), wq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Controller for the register-file write port at the end of the write-back stage.
- The port is shared between two sources:
  - the in-order pipeline (WB stage result or load data);
  - a long-latency unit (mul/div/CSR) that returns results out of band.
- The pipeline has priority. A starvation guard briefly stalls the pipeline so a waiting long-unit result can retire.
- Output is registered and drives the reg_file write port directly.

Parameters:
- XLEN, 64, data width of the write port.
- STARVE_LIMIT, 4, number of consecutive denied cycles of a pending long-unit request before a forced grant; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- pipe_valid_i  input  1  WB stage holds a valid instruction this cycle
- pipe_rd_wen_i  input  1  that instruction writes rd
- pipe_rd_addr_i  input  5  destination register
- pipe_rd_data_i  input  XLEN  ALU result
- pipe_mem_read_i  input  1  instruction is a load; select mem data
- pipe_mem_rdata_i  input  XLEN  load data
- pipe_stall_o  output  1  WB stage must hold its inputs this cycle
- lu_valid_i  input  1  long unit has a result pending
- lu_rd_addr_i  input  5  long-unit destination
- lu_rd_data_i  input  XLEN  long-unit result
- lu_ready_o  output  1  long-unit result accepted this cycle
- wb_rd_wen_o  output  1  reg_file write enable (registered)
- wb_rd_addr_o  output  5  reg_file write address (registered)
- wb_rd_wdata_o  output  XLEN  reg_file write data (registered)

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - wb_rd_wen_o=0, wb_rd_addr_o=0, wb_rd_wdata_o=0.
  - state=ARB, starve counter=0.
  - pipe_stall_o and lu_ready_o are 0 while rst=1.
  - Reset mid-wait discards the count. The long unit keeps lu_valid_i high and re-competes from count 0.
- pipe_req = pipe_valid_i & pipe_rd_wen_i. A pipeline instruction with no rd write never occupies the port.
- Pipeline data select: pipe_mem_read_i ? pipe_mem_rdata_i : pipe_rd_data_i.
- States:
  - ARB:
    - lu_ready_o = lu_valid_i & ~pipe_req.
    - pipe_stall_o = 0.
    - The pipeline wins whenever pipe_req=1.
  - FORCE:
    - lu_ready_o = lu_valid_i.
    - pipe_stall_o = pipe_req.
    - The long unit wins. A pipeline instruction with pipe_req=0 is not stalled.
- Transitions:
  - ARB->FORCE when lu_valid_i & ~lu_ready_o and counter == STARVE_LIMIT-1 (registered at that edge).
  - FORCE->ARB unconditionally after one cycle.
  - If lu_valid_i drops while in FORCE, nothing is written and the pipeline is not stalled.
- Counter:
  - Increments on each ARB cycle with lu_valid_i & ~lu_ready_o.
  - Clears on any lu handshake, when lu_valid_i=0, or on entering FORCE.
  - Saturates; never wraps.
- lu_ready_o and pipe_stall_o are combinational from current state and inputs. No combinational path from lu_ready_o back into the lu inputs is required.
- Long-unit handshake:
  - Transfer occurs when lu_valid_i & lu_ready_o.
  - Long-unit inputs must stay stable while lu_valid_i=1 and lu_ready_o=0.
  - lu_valid_i may fall only after the transfer.
- Write register, 1-cycle latency:
  - At the edge, the winning source's (addr, data) is captured and wb_rd_wen_o=1.
  - If there is no winner, wb_rd_wen_o=0 and addr/data hold their previous values.
- x0 rule: a winner with rd_addr=0 is still granted and consumed, but wb_rd_wen_o=0.
- At most one write per cycle. Both sources are never written in the same cycle.
- Simultaneous pipe_req and lu_valid_i in ARB: pipeline written; long unit waits and counts.

Test Plan:
- Pipe only: pipe_valid=1, wen=1, addr=5, data=0x11, mem_read=0 -> next cycle wen_o=1, addr_o=5, wdata_o=0x11. Same with mem_read=1, mem_rdata=0x22 -> wdata_o=0x22.
- Idle pipe: lu_valid=1, addr=7, data=0xABCD, pipe_req=0 -> lu_ready_o=1 same cycle; next cycle wen_o=1, addr_o=7, wdata_o=0xABCD.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: pipe_req=1 every cycle (addrs 1,2,3,...) with lu_valid held high.
  - Response: pipeline writes for 4 cycles. Cycle 5: pipe_stall_o=1, lu_ready_o=1, long-unit result written.
  - Cycle 6: the stalled pipe instruction is written unchanged; the counter has restarted.
- Non-writing pipe instruction: pipe_valid=1, pipe_rd_wen=0 with lu_valid=1 -> lu_ready_o=1, pipe_stall_o=0, long-unit result written.
- x0: pipe addr=0, wen=1, data=0xFF -> wen_o=0 next cycle. Same for a long-unit addr=0 -> lu_ready_o=1, wen_o=0.
- Reset mid-wait: counter at 2, assert rst one cycle -> all outputs 0, state ARB. After release the long unit needs 4 more denied cycles before FORCE.
